// File: rtl/vtg_pkg.sv
// -----------------------------------------------------------------------------
// vtg_pkg
// Shared constants for the video timing generator and the TMDS output path:
//   - default 640x480@60 raster timing (25.175 MHz pixel clock)
//   - bit positions of hsync/vsync inside the 2-bit encoder CD bus
//   - TMDS control-period code words used by the encoders during blanking
// No ports (package).
// -----------------------------------------------------------------------------
package vtg_pkg;

  // 640x480@60 raster
  localparam int VTG_H_ACTIVE = 640;
  localparam int VTG_H_FP     = 16;
  localparam int VTG_H_SYNC   = 96;
  localparam int VTG_H_BP     = 48;
  localparam int VTG_V_ACTIVE = 480;
  localparam int VTG_V_FP     = 10;
  localparam int VTG_V_SYNC   = 2;
  localparam int VTG_V_BP     = 33;
  localparam int VTG_CW       = 12;

  // Encoder CD bus layout: {vsync, hsync}
  localparam int CD_HSYNC = 0;
  localparam int CD_VSYNC = 1;

  // TMDS control-period symbols, indexed by the 2-bit CD value
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic int vtg_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vtg_pattern.sv
// -----------------------------------------------------------------------------
// vtg_pattern
// Eight-bar colour test pattern. Bar i (each H_ACTIVE/8 pixels wide) drives
// red={8{i[2]}}, green={8{i[1]}}, blue={8{i[0]}}. Outputs are registered on
// the same edge as the timing outputs so they line up with vde, and are black
// outside active video and in reset.
// Ports:
//   pixclk        in   pixel clock
//   rst           in   synchronous active-high reset
//   vde_nxt       in   active-video decode of the pre-edge counters
//   h_cnt         in   pre-edge horizontal counter
//   red/green/blue out  8-bit registered colour components
// -----------------------------------------------------------------------------
module vtg_pattern #(
  parameter int H_ACTIVE = 640,
  parameter int CW       = 12
) (
  input  logic          pixclk,
  input  logic          rst,
  input  logic          vde_nxt,
  input  logic [CW-1:0] h_cnt,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_p0;

  // Bar index by threshold comparison: avoids a divider and only matters
  // while vde_nxt is high, i.e. h_cnt < H_ACTIVE.
  always_comb begin
    bar_p0 = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= CW'(k * BAR_W)) bar_p0 = 3'(k);
    end
  end

  // ---- stage p1: registered colour, aligned with vde ----
  always_ff @(posedge pixclk) begin
    if (rst) begin
      red   <= 8'h00;
      green <= 8'h00;
      blue  <= 8'h00;
    end else if (vde_nxt) begin
      red   <= {8{bar_p0[2]}};
      green <= {8{bar_p0[1]}};
      blue  <= {8{bar_p0[0]}};
    end else begin
      red   <= 8'h00;
      green <= 8'h00;
      blue  <= 8'h00;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Pixel-rate raster timing for the DVI/HDMI output path. Two free-running
// counters (h_cnt, v_cnt) are decoded and registered each pixclk edge; all
// outputs reflect the pre-edge counter values.
// Optional build macro: VTG_PATTERN_EN adds a registered colour-bar pattern
// on red/green/blue (ports absent when the macro is undefined).
// Ports:
//   pixclk       in   pixel clock
//   rst          in   synchronous active-high reset
//   vde          out  active-video flag (registered)
//   hsync/vsync  out  syncs at HS_POL/VS_POL when asserted (registered)
//   cd           out  {vsync, hsync} for the blue-channel encoder CD input
//   x, y         out  pixel column/row of the current output cycle
//   line_start   out  pulse when x==0
//   frame_start  out  pulse when x==0 and y==0
//   red/green/blue out  colour bars (VTG_PATTERN_EN only)
// -----------------------------------------------------------------------------
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int   H_ACTIVE = VTG_H_ACTIVE,
  parameter int   H_FP     = VTG_H_FP,
  parameter int   H_SYNC   = VTG_H_SYNC,
  parameter int   H_BP     = VTG_H_BP,
  parameter int   V_ACTIVE = VTG_V_ACTIVE,
  parameter int   V_FP     = VTG_V_FP,
  parameter int   V_SYNC   = VTG_V_SYNC,
  parameter int   V_BP     = VTG_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = VTG_CW
) (
  input  logic          pixclk,
  input  logic          rst,
  output logic          vde,
  output logic          hsync,
  output logic          vsync,
  output logic [1:0]    cd,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
`ifdef VTG_PATTERN_EN
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
`endif
  output logic          frame_start
);

  localparam int H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_check
      $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Half-open window test lo <= cnt < hi
  function automatic logic in_window(input logic [CW-1:0] cnt,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  logic [CW-1:0] h_cnt_p0;
  logic [CW-1:0] v_cnt_p0;
  logic          vde_nxt_p0;
  logic          hs_nxt_p0;
  logic          vs_nxt_p0;

  // ---- stage p0: raster counters ----
  always_ff @(posedge pixclk) begin
    if (rst) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (h_cnt_p0 == H_LAST) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 1'b1;
    end else begin
      h_cnt_p0 <= h_cnt_p0 + 1'b1;
    end
  end

  // vsync is decoded from v_cnt alone, and v_cnt only changes on the edge
  // where h_cnt wraps, so vsync transitions are line-aligned for free.
  always_comb begin
    vde_nxt_p0 = (h_cnt_p0 < H_ACT_C) && (v_cnt_p0 < V_ACT_C);
    hs_nxt_p0  = in_window(h_cnt_p0, HS_BEG, HS_END) ? HS_POL : ~HS_POL;
    vs_nxt_p0  = in_window(v_cnt_p0, VS_BEG, VS_END) ? VS_POL : ~VS_POL;
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge pixclk) begin
    if (rst) begin
      vde         <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vde         <= vde_nxt_p0;
      hsync       <= hs_nxt_p0;
      vsync       <= vs_nxt_p0;
      x           <= h_cnt_p0;
      y           <= v_cnt_p0;
      line_start  <= (h_cnt_p0 == '0);
      frame_start <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    end
  end

  always_comb begin
    cd           = 2'b00;
    cd[CD_HSYNC] = hsync;
    cd[CD_VSYNC] = vsync;
  end

`ifdef VTG_PATTERN_EN
  vtg_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .CW       (CW)
  ) u_pattern (
    .pixclk  (pixclk),
    .rst     (rst),
    .vde_nxt (vde_nxt_p0),
    .h_cnt   (h_cnt_p0),
    .red     (red),
    .green   (green),
    .blue    (blue)
  );
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  // Reduced raster so several full frames fit in a short run
  localparam int   HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int   VA = 6,  VFP = 2, VSW = 2, VBP = 2;
  localparam logic HP = 1'b0, VP = 1'b0;
  localparam int   CW = 8;
  localparam int   HT = HA + HFP + HSW + HBP;
  localparam int   VT = VA + VFP + VSW + VBP;
  localparam int   FT = HT * VT;

  logic          pixclk = 1'b0;
  logic          rst = 1'b1;
  logic          vde, hsync, vsync, line_start, frame_start;
  logic [1:0]    cd;
  logic [CW-1:0] x, y;
`ifdef VTG_PATTERN_EN
  logic [7:0]    red, green, blue;
`endif

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HS_POL (HP), .VS_POL (VP), .CW (CW)
  ) dut (
    .pixclk      (pixclk),
    .rst         (rst),
    .vde         (vde),
    .hsync       (hsync),
    .vsync       (vsync),
    .cd          (cd),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
`ifdef VTG_PATTERN_EN
    .red         (red),
    .green       (green),
    .blue        (blue),
`endif
    .frame_start (frame_start)
  );

  always #5 pixclk = ~pixclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: idx = position in the output pixel stream (-1 = reset state)
  int idx = -1;
  int cyc = 0;
  int last_fs = -1;

  task automatic check_outputs();
    int h, v, bar;
    logic e_vde, e_hs, e_vs;
    if (idx < 0) begin
      check("rst_vde", vde, 0);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_ls", line_start, 0);
      check("rst_fs", frame_start, 0);
      check("rst_cd", cd, {~VP, ~HP});
`ifdef VTG_PATTERN_EN
      check("rst_rgb", {red, green, blue}, 0);
`endif
    end else begin
      h = idx % HT;
      v = idx / HT;
      e_vde = (h < HA) && (v < VA);
      e_hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HP : ~HP;
      e_vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VP : ~VP;
      check("vde", vde, e_vde);
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("cd", cd, {e_vs, e_hs});
      check("x", x, h);
      check("y", y, v);
      check("line_start", line_start, h == 0);
      check("frame_start", frame_start, idx == 0);
`ifdef VTG_PATTERN_EN
      bar = h / (HA / 8);
      check("red",   red,   (e_vde && (bar & 4) != 0) ? 8'hFF : 8'h00);
      check("green", green, (e_vde && (bar & 2) != 0) ? 8'hFF : 8'h00);
      check("blue",  blue,  (e_vde && (bar & 1) != 0) ? 8'hFF : 8'h00);
`endif
    end
  endtask

  // One clock edge with rst=r, then compare at the following falling edge
  task automatic step(input logic r);
    rst = r;
    @(posedge pixclk);
    if (r) idx = -1;
    else idx = (idx < 0) ? 0 : (idx + 1) % FT;
    cyc++;
    if (r) last_fs = -1;
    @(negedge pixclk);
    check_outputs();
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check("fs_period", cyc - last_fs, FT);
      last_fs = cyc;
    end
  endtask

  int n_vde, n_hs, n_vs, guard;
  logic prev_vs;

  initial begin
    // Reset held 5 cycles
    repeat (5) step(1'b1);
    // First edge after release
    step(1'b0);
    check("first_vde", vde, 1);
    check("first_fs", frame_start, 1);

    // Two full frames with aggregate counts per frame
    for (int f = 0; f < 2; f++) begin
      n_vde = 0; n_hs = 0; n_vs = 0;
      prev_vs = vsync;
      for (int i = 0; i < FT; i++) begin
        step(1'b0);
        if (vde === 1'b1) n_vde++;
        if (hsync === HP) n_hs++;
        if (vsync === VP) n_vs++;
        if (vsync !== prev_vs) check("vs_edge_x", x, 0);
        if (vde === 1'b1 && y >= VA) check("vde_blank_rows", vde, 0);
        prev_vs = vsync;
      end
      check("frame_vde_cnt", n_vde, HA * VA);
      check("frame_hs_cnt", n_hs, HSW * VT);
      check("frame_vs_cnt", n_vs, VSW * HT);
    end

    // Mid-frame reset at (10,3)
    guard = 0;
    while (idx != 3 * HT + 10 && guard < 2 * FT) begin
      step(1'b0);
      guard++;
    end
    check("reach_mid", idx, 3 * HT + 10);
    step(1'b1);
    check("mid_rst_vde", vde, 0);
    step(1'b0);
    check("restart_x", x, 0);
    check("restart_y", y, 0);
    check("restart_vde", vde, 1);

    // Randomised run with sporadic resets of random length
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'b1);
      end
      step(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates pixel-rate raster timing for the DVI/HDMI output path. It produces video-data-enable, hsync/vsync, pixel coordinates and frame/line strobes.
- Sits directly upstream of the three TMDS encoders:
  - vde drives each encoder's VDE input.
  - cd = {vsync, hsync} drives the blue-channel encoder's CD input.
  - x/y feed the Tetris pixel renderer.
- Default timing is 640x480@60 (25.175 MHz pixclk).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- CW, 12, width of coordinate outputs and internal counters

Ports:
- pixclk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vde  out  1  active-video flag (registered)
- hsync  out  1  horizontal sync at HS_POL level when asserted (registered)
- vsync  out  1  vertical sync at VS_POL level when asserted (registered)
- cd  out  2  {vsync, hsync} for the encoder CD input
- x  out  CW  pixel column of the current output cycle
- y  out  CW  pixel row of the current output cycle
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 and y==0

Behaviour:
- Only one clock (pixclk). Reset is synchronous and active-high on rst. No other clocks and no enables.
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Both totals must fit in CW bits; an elaboration check fails otherwise.
- Internal counters:
  - h_cnt runs 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt runs 0..V_TOTAL-1 and wraps to 0 after h_cnt=H_TOTAL-1 on line V_TOTAL-1.
- Registered decode on every pixclk edge with rst=0. All outputs take the decode of the pre-edge counter values, and the counters advance on the same edge:
  - vde = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vsync = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL
  - vsync timing is line-aligned: it changes only with h_cnt=0.
  - x = h_cnt, y = v_cnt, unconditionally. They keep counting through blanking and are not gated by vde.
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0).
- cd is combinational: {vsync, hsync}, with bit0 = hsync.
- Latency: the first edge after reset release yields vde=1, x=0, y=0, line_start=1, frame_start=1. After that, the output pixel index equals the edge count minus 1, modulo H_TOTAL*V_TOTAL.
- Reset values:
  - h_cnt=0, v_cnt=0, vde=0, x=0, y=0, line_start=0, frame_start=0
  - hsync=~HS_POL, vsync=~VS_POL, so cd=2'b11 at default polarity
- Reset asserted mid-frame: counters and outputs return to reset values on that edge, and the frame restarts from (0,0) after release. No partial-frame recovery.
- Wrap edge: the edge that moves h_cnt from H_TOTAL-1 to 0 also moves v_cnt, and (on the last line) wraps v_cnt, in the same cycle.
- No combinational path from rst to any output except via registers; cd follows the registered syncs.

Optional Feature:
- VTG_PATTERN_EN: adds outputs red, green, blue (8 bits each, registered, aligned with vde).
  - Pattern is 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - Bar index i = 0..7 gives: red = {8{i[2]}}, green = {8{i[1]}}, blue = {8{i[0]}}.
  - All three are 0 when vde=0 and 0 in reset.
- Without the macro, the ports and logic are absent, and the renderer supplies pixel data.

Decomposition:
- Package vtg_pkg holds:
  - 640x480@60 timing constants
  - CD bit-index constants (CD_HSYNC=0, CD_VSYNC=1)
  - the TMDS control-period code constants shared with the encoders
- One natural sub-module: vtg_pattern (colour-bar generator), instantiated only under VTG_PATTERN_EN.

Test Plan:
- Reset held 5 cycles, then released → first edge: vde=1, x=0, y=0, frame_start=1. Before that: cd=2'b11, vde=0.
- Run one line → vde high for exactly 640 cycles (x=0..639), then low for 160 cycles. hsync=0 exactly for x=656..751 (96 cycles). line_start period is 800 cycles.
- Run a full frame → frame_start period = 420000 cycles. vsync=0 exactly for y=490..491, changing only when x=0. vde never 1 for y≥480.
- Wrap check → the cycle after x=799, y=524 shows x=0, y=0, frame_start=1.
- Assert rst at x=300, y=200 for 1 cycle → next output vde=0, x=0, y=0. After release, restart at (0,0) with vde=1.
- With VTG_PATTERN_EN:
  - x=0 → rgb=000000. x=80 → blue=FF, red=green=00. x=639 → all FF.
  - All rgb=0 while vde=0.
